// File: rtl/twiddle_mult.sv
// ============================================================================
// Module      : twiddle_mult
// Description : Radix-2^2 inter-stage twiddle multiplier, 3-cycle pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_mult #(
  parameter int N        = 64,
  parameter int WIDTH    = 8,
  parameter int TW_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_in,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    enable_out,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int  c_mw     = $clog2(N);
  localparam int  c_pw     = c_mw - 2;
  localparam int  c_prod_w = WIDTH + TW_WIDTH;
  localparam int  c_sum_w  = WIDTH + TW_WIDTH + 1;
  localparam int  c_tw_max = 2**(TW_WIDTH-1) - 1;
  localparam real c_pi     = 3.14159265358979323846;

  localparam logic signed [c_sum_w-1:0] c_round  = c_sum_w'(2**(TW_WIDTH-2));
  localparam logic signed [c_sum_w-1:0] c_sat_hi = c_sum_w'(2**(WIDTH-1) - 1);
  localparam logic signed [c_sum_w-1:0] c_sat_lo = c_sum_w'(-(2**(WIDTH-1)));

  function automatic int round_r(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [c_sum_w-1:0] x);
    if (x > c_sat_hi)      return c_sat_hi[WIDTH-1:0];
    else if (x < c_sat_lo) return c_sat_lo[WIDTH-1:0];
    else                   return x[WIDTH-1:0];
  endfunction

  // Coefficient ROM, fully resolved at elaboration
  logic signed [TW_WIDTH-1:0] w_tw_re [N];
  logic signed [TW_WIDTH-1:0] w_tw_im [N];

  for (genvar g = 0; g < N; g++) begin : g_tw
    localparam int c_re = round_r($cos(2.0 * c_pi * g / N) * c_tw_max);
    localparam int c_im = round_r(-$sin(2.0 * c_pi * g / N) * c_tw_max);
    assign w_tw_re[g] = TW_WIDTH'(c_re);
    assign w_tw_im[g] = TW_WIDTH'(c_im);
  end

  logic [c_mw-1:0] r_m;
  logic [1:0]      w_q;
  logic [1:0]      w_qbr;
  logic [c_pw-1:0] w_p;
  logic [c_mw-1:0] w_e;

  assign w_q   = r_m[c_mw-1 -: 2];
  assign w_p   = r_m[c_pw-1:0];
  // bit-reversing the quarter index gives 0,2,1,3
  assign w_qbr = {w_q[0], w_q[1]};
  assign w_e   = c_mw'(w_qbr) * c_mw'(w_p);

  logic                    r_v1, r_byp1;
  logic [c_mw-1:0]         r_e1;
  logic signed [WIDTH-1:0] r_re1, r_im1;

  logic                    r_v2, r_byp2;
  logic signed [WIDTH-1:0] r_re2, r_im2;
  logic signed [c_prod_w-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;

  logic signed [c_prod_w-1:0] w_xr, w_xi, w_wr, w_wi;
  assign w_xr = c_prod_w'(r_re1);
  assign w_xi = c_prod_w'(r_im1);
  assign w_wr = c_prod_w'(w_tw_re[r_e1]);
  assign w_wi = c_prod_w'(w_tw_im[r_e1]);

  logic signed [c_sum_w-1:0] w_sr, w_si, w_shr, w_shi;
  assign w_sr  = c_sum_w'(r_p_rr) - c_sum_w'(r_p_ii) + c_round;
  assign w_si  = c_sum_w'(r_p_ri) + c_sum_w'(r_p_ir) + c_round;
  assign w_shr = w_sr >>> (TW_WIDTH-1);
  assign w_shi = w_si >>> (TW_WIDTH-1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m        <= '0;
      r_v1       <= 1'b0;
      r_byp1     <= 1'b0;
      r_e1       <= '0;
      r_re1      <= '0;
      r_im1      <= '0;
      r_v2       <= 1'b0;
      r_byp2     <= 1'b0;
      r_re2      <= '0;
      r_im2      <= '0;
      r_p_rr     <= '0;
      r_p_ii     <= '0;
      r_p_ri     <= '0;
      r_p_ir     <= '0;
      enable_out <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      r_m    <= enable_in ? r_m + c_mw'(1) : '0;

      r_v1   <= enable_in;
      r_byp1 <= (w_e == '0);
      r_e1   <= w_e;
      r_re1  <= in_re;
      r_im1  <= in_im;

      r_v2   <= r_v1;
      r_byp2 <= r_byp1;
      r_re2  <= r_re1;
      r_im2  <= r_im1;
      r_p_rr <= w_xr * w_wr;
      r_p_ii <= w_xi * w_wi;
      r_p_ri <= w_xr * w_wi;
      r_p_ir <= w_xi * w_wr;

      enable_out <= r_v2;
      if (!r_v2) begin
        out_re <= '0;
        out_im <= '0;
      end else if (r_byp2) begin
        out_re <= r_re2;
        out_im <= r_im2;
      end else begin
        out_re <= sat(w_shr);
        out_im <= sat(w_shi);
      end
    end
  end

endmodule

`default_nettype wire
